// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, sequencer states
// and the default program-counter width.
package cpu8_pkg;

    localparam int CPU_AW = 7;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_JC   = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO used by CALL/RET. Push and pop are never requested in the
// same cycle; a push while full or a pop while empty is ignored here, the
// sequencer turns those cases into an error.
module ret_stack
    import cpu8_pkg::*;
#(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] depth_o
);

    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [DW-1:0] depth_q;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;
    assign top_idx = IW'(depth_q - DW'(1));
    assign wr_idx  = IW'(depth_q);
    assign top_o   = mem[top_idx];

    // Occupancy counter: grows on an accepted push, shrinks on an accepted pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= '0;
        end else if (push_i && !full_o) begin
            depth_q <= depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    // Entry storage: contents need no reset because depth gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && !full_o) begin
            mem[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: each cycle chooses pc+1, a taken branch, a hold
// or a PC reset for branch_unit. branch_* outputs are combinational so that
// branch_unit acts on them at the same edge; state, stall counter, error flag
// and return stack are registered.
module pc_sequencer
    import cpu8_pkg::*;
#(
    parameter int AW          = CPU_AW,
    parameter int STACK_DEPTH = 4,
    parameter int SW          = 4,
    localparam int DW         = $clog2(STACK_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] pc_i,
    input  logic          op_valid_i,
    input  logic [2:0]    op_i,
    input  logic [AW-1:0] target_i,
    input  logic          zero_flag_i,
    input  logic          carry_flag_i,
    input  logic [SW-1:0] stall_cycles_i,
    input  logic          resume_i,
    output logic          rst_pc_o,
    output logic          branch_en_o,
    output logic [AW-1:0] branch_addr_o,
    output logic          halted_o,
    output logic          stack_err_o,
    output logic [DW-1:0] stack_depth_o
);

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          push, pop, apply;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty;

    assign pc_inc      = pc_i + AW'(1);
    assign rst_pc_o    = rst_i;
    assign halted_o    = (state_q == ST_HALT);
    assign stack_err_o = err_q;

    ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .depth_o (stack_depth_o)
    );

    // Next-state, stack requests and branch mux; while in reset everything stays idle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        push          = 1'b0;
        pop           = 1'b0;
        apply         = 1'b0;
        branch_en_o   = 1'b0;
        branch_addr_o = '0;

        if (!rst_i) begin
            case (state_q)
                ST_RUN: begin
                    if (op_valid_i) begin
                        if (stall_cycles_i != '0) begin
                            branch_en_o   = 1'b1;
                            branch_addr_o = pc_i;
                            cnt_d         = stall_cycles_i - SW'(1);
                            state_d       = ST_STALL;
                        end else begin
                            apply = 1'b1;
                        end
                    end
                end
                ST_STALL: begin
                    if (cnt_q != '0) begin
                        branch_en_o   = 1'b1;
                        branch_addr_o = pc_i;
                        cnt_d         = cnt_q - SW'(1);
                    end else begin
                        state_d = ST_RUN;
                        apply   = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume_i && !err_q) begin
                        state_d = ST_RUN;
                    end else begin
                        branch_en_o   = 1'b1;
                        branch_addr_o = pc_i;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            if (apply) begin
                case (op_i)
                    OP_NOP: begin
                    end
                    OP_JMP: begin
                        branch_en_o   = 1'b1;
                        branch_addr_o = target_i;
                    end
                    OP_JZ: begin
                        branch_en_o   = zero_flag_i;
                        branch_addr_o = target_i;
                    end
                    OP_JNZ: begin
                        branch_en_o   = !zero_flag_i;
                        branch_addr_o = target_i;
                    end
                    OP_JC: begin
                        branch_en_o   = carry_flag_i;
                        branch_addr_o = target_i;
                    end
                    OP_CALL: begin
                        branch_en_o = 1'b1;
                        if (stk_full) begin
                            branch_addr_o = pc_i;
                            err_d         = 1'b1;
                            state_d       = ST_HALT;
                        end else begin
                            push          = 1'b1;
                            branch_addr_o = target_i;
                        end
                    end
                    OP_RET: begin
                        branch_en_o = 1'b1;
                        if (stk_empty) begin
                            branch_addr_o = pc_i;
                            err_d         = 1'b1;
                            state_d       = ST_HALT;
                        end else begin
                            pop           = 1'b1;
                            branch_addr_o = stk_top;
                        end
                    end
                    OP_HALT: begin
                        branch_en_o   = 1'b1;
                        branch_addr_o = pc_i;
                        state_d       = ST_HALT;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State register, stall counter and sticky stack error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
